// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, FSM states and digit-sizing helper for the sequential BCD converter.
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH = 5;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int min_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble add-3 correction for one BCD digit (wraps mod 16).
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);
  assign dout = din >= BCD_DIGIT_W'(ADJ_THRESH) ? din + BCD_DIGIT_W'(3) : din;
endmodule

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: iterative double-dabble binary to packed BCD with start/busy/done handshake and overflow flag.
// Leading-zero blanking is built only when SEQ_BIN2BCD_BLANK_EN is defined; otherwise blank is tied low.
module seq_bin2bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf,
  output logic [DIGITS-1:0]             blank
);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  if (BIN_W < 1 || DIGITS < 1) begin : g_bad_params
    $error("seq_bin2bcd: BIN_W and DIGITS must both be >= 1");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_narrow
    $info("seq_bin2bcd: DIGITS=%0d cannot hold every BIN_W=%0d value; ovf may assert", DIGITS, BIN_W);
  end
  state_t state, state_n;
  logic [BCD_W-1:0] scratch, adj, scratch_n;
  logic [BIN_W-1:0] shadow, shadow_n;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W+BIN_W:0] shifted;
  logic ovf_acc, ovf_n, last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din (scratch[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .dout(adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end
  // The top bit of the shifted vector is the carry out of the highest digit.
  assign shifted   = {adj, shadow, 1'b0};
  assign scratch_n = shifted[BCD_W+BIN_W-1:BIN_W];
  assign shadow_n  = shifted[BIN_W-1:0];
  assign ovf_n     = ovf_acc | shifted[BCD_W+BIN_W];
  assign last      = cnt == CNT_W'(1);
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? SHIFT :
              (state == SHIFT && last) ? DONE  :
              (state == DONE)          ? IDLE  : state;
  end
  // Results load on the final shift so they are already valid in the DONE cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scratch <= '0;
      shadow  <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else if (state == IDLE && start) begin
      scratch <= '0;
      shadow  <= bin;
      cnt     <= CNT_W'(BIN_W);
      ovf_acc <= 1'b0;
    end else if (state == SHIFT) begin
      scratch <= scratch_n;
      shadow  <= shadow_n;
      cnt     <= cnt - CNT_W'(1);
      ovf_acc <= ovf_n;
      if (last) begin
        bcd <= scratch_n;
        ovf <= ovf_n;
      end
    end
  end
`ifdef SEQ_BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_n;
  logic zero;
  always_comb begin
    blank_n = '0;
    zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero = zero && (scratch_n[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
      blank_n[k] = zero;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) blank <= '0;
    else if (state == SHIFT && last) blank <= blank_n;
  end
`else
  assign blank = '0;
`endif
endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb_seq_bin2bcd: scoreboard bench for seq_bin2bcd in 8/3, 16/5 and 8/2 configurations.
module tb_seq_bin2bcd;
  typedef struct packed {
    logic [19:0] bcd;
    logic        ovf;
    logic [4:0]  blank;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s3 = 1'b0, s5 = 1'b0, s2 = 1'b0;
  logic [7:0]  b3 = '0, b2 = '0;
  logic [15:0] b5 = '0;
  logic bz3, dn3, of3, bz5, dn5, of5, bz2, dn2, of2;
  logic [11:0] q3;
  logic [19:0] q5;
  logic [7:0]  q2;
  logic [2:0]  bl3;
  logic [4:0]  bl5;
  logic [1:0]  bl2;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_bin2bcd #(.BIN_W(8), .DIGITS(3)) u3 (.CLOCK_50(clk), .reset(rst), .start(s3), .bin(b3),
    .busy(bz3), .done(dn3), .bcd(q3), .ovf(of3), .blank(bl3));
  seq_bin2bcd #(.BIN_W(16), .DIGITS(5)) u5 (.CLOCK_50(clk), .reset(rst), .start(s5), .bin(b5),
    .busy(bz5), .done(dn5), .bcd(q5), .ovf(of5), .blank(bl5));
  seq_bin2bcd #(.BIN_W(8), .DIGITS(2)) u2 (.CLOCK_50(clk), .reset(rst), .start(s2), .bin(b2),
    .busy(bz2), .done(dn2), .bcd(q2), .ovf(of2), .blank(bl2));

  function automatic exp_t exp_of(input int v, input int nd);
    exp_t e;
    int p;
    e = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      e.bcd[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    e.ovf = v >= p;
`ifdef SEQ_BIN2BCD_BLANK_EN
    begin
      int pk;
      pk = 1;
      for (int k = 1; k < nd; k++) begin
        pk = pk * 10;
        e.blank[k] = (v % p) < pk;
      end
    end
`endif
    return e;
  endfunction

  function automatic exp_t cur(input int w);
    exp_t o;
    o = '0;
    if (w == 0) begin o.bcd = {8'd0, q3}; o.ovf = of3; o.blank = {2'd0, bl3}; end
    if (w == 1) begin o.bcd = q5; o.ovf = of5; o.blank = bl5; end
    if (w == 2) begin o.bcd = {12'd0, q2}; o.ovf = of2; o.blank = {3'd0, bl2}; end
    return o;
  endfunction

  task automatic kick(input int w, input int v);
    @(posedge clk); #1;
    if (w == 0) begin s3 = 1'b1; b3 = 8'(v); end
    if (w == 1) begin s5 = 1'b1; b5 = 16'(v); end
    if (w == 2) begin s2 = 1'b1; b2 = 8'(v); end
    exp_q.push_back(exp_of(v, w == 0 ? 3 : w == 1 ? 5 : 2));
    @(posedge clk); #1;
    s3 = 1'b0; s5 = 1'b0; s2 = 1'b0;
    b3 = 8'($urandom); b5 = 16'($urandom); b2 = 8'($urandom);
  endtask

  task automatic wait_done(input int w, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40 && cyc < 0; c++) begin
      @(negedge clk);
      if ((w == 0 && dn3) || (w == 1 && dn5) || (w == 2 && dn2)) cyc = c;
      else @(posedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bz3, dn3, q3, of3, bl3} !== '0) begin n_bad++;
      $display("FAIL reset_u3 got busy=%b done=%b bcd=%h ovf=%b blank=%b want all 0", bz3, dn3, q3, of3, bl3); end
    n_cmp++;
    if ({bz5, dn5, q5, of5, bl5} !== '0) begin n_bad++;
      $display("FAIL reset_u5 got busy=%b done=%b bcd=%h ovf=%b blank=%b want all 0", bz5, dn5, q5, of5, bl5); end
    n_cmp++;
    if ({bz2, dn2, q2, of2, bl2} !== '0) begin n_bad++;
      $display("FAIL reset_u2 got busy=%b done=%b bcd=%h ovf=%b blank=%b want all 0", bz2, dn2, q2, of2, bl2); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_latency;
    exp_t e;
    kick(0, 255);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bz3 !== (c <= 9) || dn3 !== (c == 9)) begin n_bad++;
        $display("FAIL latency_c%0d got busy=%b done=%b want busy=%b done=%b", c, bz3, dn3, c <= 9, c == 9); end
      if (c == 9) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (cur(0) !== e || e.bcd !== 20'h00255) begin n_bad++;
          $display("FAIL latency_255 got %h/%b/%b want %h/%b/%b", cur(0).bcd, cur(0).ovf, cur(0).blank, e.bcd, e.ovf, e.blank); end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_zero;
    exp_t e;
    int cyc;
    kick(0, 0);
    wait_done(0, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (cyc != 9) begin n_bad++; $display("FAIL zero_latency got %0d want 9", cyc); end
    n_cmp++;
    if (cur(0) !== e) begin n_bad++;
      $display("FAIL zero got %h/%b/%b want %h/%b/%b", cur(0).bcd, cur(0).ovf, cur(0).blank, e.bcd, e.ovf, e.blank); end
  endtask

  task automatic test_wide;
    exp_t e;
    int cyc;
    int vals[2] = '{65535, 1000};
    foreach (vals[i]) begin
      kick(1, vals[i]);
      wait_done(1, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (cyc != 17) begin n_bad++; $display("FAIL wide_latency_%0d got %0d want 17", vals[i], cyc); end
      n_cmp++;
      if (cur(1) !== e) begin n_bad++;
        $display("FAIL wide_%0d got %h/%b/%b want %h/%b/%b", vals[i], cur(1).bcd, cur(1).ovf, cur(1).blank, e.bcd, e.ovf, e.blank); end
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    int cyc;
    int vals[4] = '{100, 99, 255, 7};
    foreach (vals[i]) begin
      kick(2, vals[i]);
      wait_done(2, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (cyc < 0 || cur(2) !== e) begin n_bad++;
        $display("FAIL ovf_%0d cyc=%0d got %h/%b/%b want %h/%b/%b", vals[i], cyc, cur(2).bcd, cur(2).ovf, cur(2).blank, e.bcd, e.ovf, e.blank); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(posedge clk); #1;
    s3 = 1'b1; b3 = 8'd42;
    exp_q.push_back(exp_of(42, 3));
    @(posedge clk); #1;
    b3 = 8'd7;
    exp_q.push_back(exp_of(7, 3));
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dn3 !== (c == 9 || c == 19)) begin n_bad++;
        $display("FAIL b2b_done_c%0d got %b want %b", c, dn3, c == 9 || c == 19); end
      if (dn3 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (cur(0) !== e) begin n_bad++;
          $display("FAIL b2b_c%0d got %h/%b/%b want %h/%b/%b", c, cur(0).bcd, cur(0).ovf, cur(0).blank, e.bcd, e.ovf, e.blank); end
      end
      @(posedge clk); #1;
      if (c == 10) s3 = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_pending got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_abort;
    exp_t e;
    int cyc;
    kick(0, 200);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dn3 !== 1'b0) begin n_bad++; $display("FAIL abort_done_c%0d got %b want 0", c, dn3); end
      if (c == 5) begin
        n_cmp++;
        if ({bz3, q3, of3, bl3} !== '0) begin n_bad++;
          $display("FAIL abort_clear got busy=%b bcd=%h ovf=%b blank=%b want 0", bz3, q3, of3, bl3); end
      end
      @(posedge clk); #1;
      rst = (c == 3);
    end
    void'(exp_q.pop_front());
    kick(0, 17);
    wait_done(0, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (cyc != 9 || cur(0) !== e) begin n_bad++;
      $display("FAIL abort_restart cyc=%0d got %h/%b/%b want 9 %h/%b/%b", cyc, cur(0).bcd, cur(0).ovf, cur(0).blank, e.bcd, e.ovf, e.blank); end
  endtask

  task automatic test_random;
    exp_t e;
    int cyc, v;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 255));
      kick(0, v);
      wait_done(0, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (cyc != 9 || cur(0) !== e) begin n_bad++;
        $display("FAIL rand_%0d cyc=%0d got %h/%b/%b want %h/%b/%b", v, cyc, cur(0).bcd, cur(0).ovf, cur(0).blank, e.bcd, e.ovf, e.blank); end
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_zero;
    test_wide;
    test_overflow;
    test_back_to_back;
    test_abort;
    test_random;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
